// File: rtl/ram_pkg.sv
// Shared sizing and word types for the modport_ram storage block.
package ram_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // All-zero word used for reset clears and safe defaults.
  function automatic data_t zero_word();
    return data_t'(0);
  endfunction

endpackage : ram_pkg

// File: rtl/ram_core.sv
// Storage array for modport_ram.
// It provides the write port, a synchronous clear, and a combinational peek at the read address.
// The peek reflects the array before any write landing on the same edge, which gives the
// top-level read register its read-before-write behaviour.
module ram_core
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_enb,
  input  addr_t wr_addr,
  input  data_t wr_data,
  input  addr_t rd_addr,
  output data_t rd_word
);

  data_t r_mem [DEPTH];

  // Storage update: reset clears every word, otherwise the enabled write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= zero_word();
      end
    end else if (wr_enb) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Current contents at the read address; the top registers this value.
  always_comb begin
    rd_word = r_mem[rd_addr];
  end

endmodule : ram_core

// File: rtl/modport_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, single clock.
// Read data has one cycle of latency and holds its value while rd_enb is low.
module modport_ram
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  data_t w_rd_word;
  data_t r_rd_data;
  data_t w_rd_next;

  ram_core u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_enb  (wr_enb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_word (w_rd_word)
  );

  // Next read-register value: capture the stored word on a read, hold otherwise.
  always_comb begin
    w_rd_next = r_rd_data;
    if (rd_enb) begin
      w_rd_next = w_rd_word;
    end else begin
      w_rd_next = r_rd_data;
    end
  end

  // Read data register; reset has priority over any read in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= zero_word();
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign rd_data = r_rd_data;

endmodule : modport_ram

// File: tb/tb_modport_ram.sv
// Self-checking bench for modport_ram using a reference memory and an expected-read queue.
module tb_modport_ram;

  logic       clk;
  logic       rst;
  logic       wr_enb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_enb;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [16];
  logic [7:0] sb_q [$];
  logic [7:0] exp_v;

  modport_ram dut (
    .clk     (clk),
    .rst     (rst),
    .wr_enb  (wr_enb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_enb  (rd_enb),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, update the reference model, and push the expected read.
  task automatic do_cycle(input bit rs, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                          input bit re, input logic [3:0] ra);
    rst     = rs;
    wr_enb  = we;
    wr_addr = wa;
    wr_data = wd;
    rd_enb  = re;
    rd_addr = ra;
    if (rs) begin
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    end else begin
      if (re) sb_q.push_back(model_mem[ra]);
      if (we) model_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_enb = 1'b0;
    rd_enb = 1'b0;
  endtask

  task automatic pop_exp(output logic [7:0] v);
    if (sb_q.size() == 0) begin
      v = 8'hxx;
    end else begin
      v = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    do_cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
    do_cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) begin
      do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
      pop_exp(exp_v);
      checks++;
      if (rd_data !== exp_v || rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_clear addr %0d: got %h expected %h", a, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_write_read();
    do_cycle(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL write_read: got %h expected A5", rd_data);
    end
  endtask

  task automatic test_rbw();
    do_cycle(1'b0, 1'b1, 4'd7, 8'h11, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b1, 4'd7, 8'h5A, 1'b1, 4'd7);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'h11) begin
      errors++;
      $display("FAIL rbw_old: got %h expected 11", rd_data);
    end
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL rbw_new: got %h expected 5A", rd_data);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++) do_cycle(1'b0, 1'b1, 4'(a), 8'(a + 1), 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) begin
      do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
      pop_exp(exp_v);
      checks++;
      if (rd_data !== exp_v) begin
        errors++;
        $display("FAIL fill addr %0d: got %h expected %h", a, rd_data, exp_v);
      end
    end
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(k));
      checks++;
      if (rd_data !== 8'h10) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected 10", k, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_cycle(1'b0, 1'b1, 4'd15, 8'hFF, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL pre_reset_read: got %h expected FF", rd_data);
    end
    do_cycle(1'b1, 1'b1, 4'd2, 8'h77, 1'b1, 4'd15);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_rd_data: got %h expected 00", rd_data);
    end
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_dropped_write: got %h expected 00", rd_data);
    end
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_cleared_15: got %h expected 00", rd_data);
    end
  endtask

  task automatic test_independent();
    do_cycle(1'b0, 1'b1, 4'd9, 8'h3C, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b1, 4'd4, 8'hC4, 1'b1, 4'd9);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL indep_read: got %h expected 3C", rd_data);
    end
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'hC4) begin
      errors++;
      $display("FAIL indep_write: got %h expected C4", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b0, 1'b1, 4'd5, 8'h11, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b1, 4'd5, 8'h22, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    pop_exp(exp_v);
    checks++;
    if (rd_data !== exp_v || rd_data !== 8'h22) begin
      errors++;
      $display("FAIL last_write_wins: got %h expected 22", rd_data);
    end
    for (int k = 0; k < 20; k++) begin
      do_cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
               1'b1, 4'($urandom_range(0, 15)));
      pop_exp(exp_v);
      checks++;
      if (rd_data !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", k, rd_data, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b0; wr_enb = 1'b0; wr_addr = 4'd0; wr_data = 8'h00; rd_enb = 1'b0; rd_addr = 4'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_rbw();
    test_fill();
    test_reset_mid();
    test_independent();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_modport_ram
